reflet_mem_map_ctrl: RTL
========================

REFLET_MEM_MAP_CTRL -- requirements
Module: reflet_mem_map_ctrl

Interface
REQ-001 SHALL have parameter wordsize, default 8: bus and address width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameters inst_base/inst_size, defaults 0/128: instruction region, in words.
REQ-003 SHALL have parameters data_base/data_size, defaults 128/109: data region.
REQ-004 SHALL have parameters periph_base/periph_size, defaults 237/19: peripheral region.
REQ-005 SHALL have parameters inst_ws/data_ws/periph_ws, defaults 0/0/0, range 0-7: per-region wait states.
REQ-006 SHALL have parameter por_cycles, default 16, range 1-255: reset stretch length in cycles.
REQ-007 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: cpu_addr in wordsize; cpu_wdata in wordsize; cpu_write_en in 1; cpu_rdata out wordsize; cpu_enable out 1, CPU advance strobe.
REQ-009 SHALL have port rst_out out 1: stretched active-low reset for the CPU and memories.
REQ-010 SHALL have ports: inst_en, data_en, periph_en out 1 each, region selects.
REQ-011 SHALL have ports: mem_addr out wordsize, region-relative offset; mem_wdata out wordsize; mem_write_en out 1.
REQ-012 SHALL have ports: inst_rdata, data_rdata, periph_rdata in wordsize each.
REQ-013 SHALL have ports: bus_err out 1, sticky flag; err_addr out wordsize; err_clr in 1.

Function
REQ-014 SHALL decode regions combinationally as base <= cpu_addr < base+size; on overlap, priority periph > data > inst; at most one select high.
REQ-015 SHALL drive mem_addr = cpu_addr - base of the selected region, and 0 when unmapped.
REQ-016 SHALL pass mem_wdata = cpu_wdata unchanged.
REQ-017 SHALL drive cpu_rdata = rdata of the selected region, and 0 when unmapped or when rst_out is low.
REQ-018 SHALL implement FSM IDLE/WAIT with 3-bit counter cnt.
- IDLE with selected ws=0: cpu_enable=1.
- IDLE with ws=k>0: cpu_enable=0, cnt<=k-1, go WAIT.
- WAIT with cnt!=0: cpu_enable=0, cnt decrements.
- WAIT with cnt=0: cpu_enable=1, go IDLE.
REQ-019 SHALL give every access with ws=k exactly k stall cycles followed by one cpu_enable cycle; for ws=0, one access per cycle.
REQ-020 SHALL assert mem_write_en = cpu_write_en & cpu_enable & (region selected), giving exactly one write strobe per access.
REQ-021 SHALL use the ws of the region decoded on the IDLE cycle, held constant until the access completes.
REQ-022 SHALL complete an unmapped access with ws=0 and no write strobe.
REQ-023 SHALL, on an unmapped access in its cpu_enable cycle, set bus_err; err_addr captures cpu_addr only when bus_err was 0 (first error kept).
REQ-024 SHALL clear bus_err and err_addr on err_clr; if err_clr and a new error occur in the same cycle, the new error wins (set and capture).
REQ-025 SHALL force cpu_enable=0 and all selects' write strobes to 0 while rst_out is low.

Reset
REQ-026 SHALL, on reset low, immediately (asynchronously) force rst_out=0, FSM=IDLE, cnt=0, bus_err=0, err_addr=0.
REQ-027 SHALL release rst_out through a 2-flop synchroniser followed by a por_cycles counter: rst_out rises exactly 2+por_cycles rising edges after reset deasserts.
REQ-028 SHALL abort an in-progress WAIT on reset assertion mid-access, with no write strobe issued.

Configuration
REQ-029 SHALL gate error logic with macro REFLET_MEM_MAP_BUS_ERR_EN.
- Defined: REQ-023/024 active.
- Undefined: bus_err=0, err_addr=0, err_clr ignored, no error registers built; decode and wait behaviour unchanged.

Verification
Default regions, data_ws=2, por_cycles=4 for all scenarios.
REQ-030 SHALL verify reset: release reset -> rst_out rises on edge 6; cpu_enable=0 until then.
REQ-031 SHALL verify inst access: cpu_addr=0x10 -> inst_en=1, mem_addr=0x10, cpu_enable=1 every cycle.
REQ-032 SHALL verify data write: write 0x5A at 0x85 -> cpu_enable pattern 0,0,1; mem_addr=0x05; one mem_write_en pulse on the third cycle.
REQ-033 SHALL verify peripheral read: cpu_addr=0xF0, periph_rdata=0x3C -> periph_en=1, mem_addr=0x03, cpu_rdata=0x3C.
REQ-034 SHALL verify errors (macro defined): regions shrunk so 0xEC is unmapped; access 0xEC then 0xEB -> bus_err=1, err_addr=0xEC; err_clr with a simultaneous error at 0xEB -> err_addr=0xEB.
REQ-035 SHALL verify reset mid-WAIT: assert reset during the second stall of a data write -> no mem_write_en pulse, FSM=IDLE.

Source files
------------

// File: rtl/reflet_mem_map_ctrl_if.sv
// ============================================================================
// Module      : reflet_cpu_bus_if / reflet_mem_bus_if
// Description : CPU-side and memory-side buses of the Reflet memory-map
//               controller. The CPU bus is mastered by the CPU. The memory
//               bus is mastered by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reflet_cpu_bus_if #(
  parameter int wordsize = 8
);
  logic [wordsize-1:0] cpu_addr;
  logic [wordsize-1:0] cpu_wdata;
  logic                cpu_write_en;
  logic [wordsize-1:0] cpu_rdata;
  logic                cpu_enable;

  modport master (
    output cpu_addr, cpu_wdata, cpu_write_en,
    input  cpu_rdata, cpu_enable
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write_en,
    output cpu_rdata, cpu_enable
  );
endinterface

interface reflet_mem_bus_if #(
  parameter int wordsize = 8
);
  logic                inst_en;
  logic                data_en;
  logic                periph_en;
  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_wdata;
  logic                mem_write_en;
  logic [wordsize-1:0] inst_rdata;
  logic [wordsize-1:0] data_rdata;
  logic [wordsize-1:0] periph_rdata;

  modport master (
    output inst_en, data_en, periph_en, mem_addr, mem_wdata, mem_write_en,
    input  inst_rdata, data_rdata, periph_rdata
  );

  modport slave (
    input  inst_en, data_en, periph_en, mem_addr, mem_wdata, mem_write_en,
    output inst_rdata, data_rdata, periph_rdata
  );
endinterface

`default_nettype wire

// File: rtl/reflet_mem_map_ctrl.sv
// ============================================================================
// Module      : reflet_mem_map_ctrl
// Description : Memory-map controller for the Reflet CPU. It decodes the
//               instruction, data and peripheral regions. It inserts
//               per-region wait states by stalling cpu_enable. It stretches
//               the external reset.
//               Optional bus-error capture is enabled by defining the macro
//               REFLET_MEM_MAP_BUS_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_mem_map_ctrl #(
  parameter int              wordsize    = 8,
  parameter longint unsigned inst_base   = 0,
  parameter longint unsigned inst_size   = 128,
  parameter longint unsigned data_base   = 128,
  parameter longint unsigned data_size   = 109,
  parameter longint unsigned periph_base = 237,
  parameter longint unsigned periph_size = 19,
  parameter int              inst_ws     = 0,
  parameter int              data_ws     = 0,
  parameter int              periph_ws   = 0,
  parameter int              por_cycles  = 16
) (
  input  logic                clk,
  input  logic                reset,
  reflet_cpu_bus_if.slave     cpu,
  reflet_mem_bus_if.master    mem,
  output logic                rst_out,
  output logic                bus_err,
  output logic [wordsize-1:0] err_addr,
  input  logic                err_clr
);

  // The decode is done one bit wider than the bus. An address below a base
  // then wraps to a value of at least 2^wordsize, which is never smaller than
  // a region size. One unsigned compare therefore covers both bounds.
  localparam int c_aw = wordsize + 1;

  localparam logic [c_aw-1:0] c_inst_lo   = c_aw'(inst_base);
  localparam logic [c_aw-1:0] c_inst_sz   = c_aw'(inst_size);
  localparam logic [c_aw-1:0] c_data_lo   = c_aw'(data_base);
  localparam logic [c_aw-1:0] c_data_sz   = c_aw'(data_size);
  localparam logic [c_aw-1:0] c_periph_lo = c_aw'(periph_base);
  localparam logic [c_aw-1:0] c_periph_sz = c_aw'(periph_size);

  localparam logic [2:0] c_inst_ws   = 3'(inst_ws);
  localparam logic [2:0] c_data_ws   = 3'(data_ws);
  localparam logic [2:0] c_periph_ws = 3'(periph_ws);

  localparam logic [7:0] c_por_last = 8'(por_cycles - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Region decode
  // --------------------------------------------------------------------------
  logic [c_aw-1:0]     w_addr_x;
  logic [c_aw-1:0]     w_off_inst;
  logic [c_aw-1:0]     w_off_data;
  logic [c_aw-1:0]     w_off_periph;
  logic                w_sel_inst;
  logic                w_sel_data;
  logic                w_sel_periph;
  logic                w_mapped;
  logic [wordsize-1:0] w_offset;
  logic [wordsize-1:0] w_rdata;
  logic [2:0]          w_ws;

  assign w_addr_x     = {1'b0, cpu.cpu_addr};
  assign w_off_inst   = w_addr_x - c_inst_lo;
  assign w_off_data   = w_addr_x - c_data_lo;
  assign w_off_periph = w_addr_x - c_periph_lo;

  // Priority select: periph over data over inst, with the matching offset, read data and wait states.
  always_comb begin
    w_sel_inst   = 1'b0;
    w_sel_data   = 1'b0;
    w_sel_periph = 1'b0;
    w_offset     = '0;
    w_rdata      = '0;
    w_ws         = 3'd0;
    if (w_off_periph < c_periph_sz) begin
      w_sel_periph = 1'b1;
      w_offset     = w_off_periph[wordsize-1:0];
      w_rdata      = mem.periph_rdata;
      w_ws         = c_periph_ws;
    end else if (w_off_data < c_data_sz) begin
      w_sel_data   = 1'b1;
      w_offset     = w_off_data[wordsize-1:0];
      w_rdata      = mem.data_rdata;
      w_ws         = c_data_ws;
    end else if (w_off_inst < c_inst_sz) begin
      w_sel_inst   = 1'b1;
      w_offset     = w_off_inst[wordsize-1:0];
      w_rdata      = mem.inst_rdata;
      w_ws         = c_inst_ws;
    end
  end

  assign w_mapped = w_sel_inst | w_sel_data | w_sel_periph;

  // --------------------------------------------------------------------------
  // Reset stretcher: 2-flop synchroniser followed by a por_cycles counter
  // --------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [7:0] por_cnt_q;
  logic       rst_out_q;

  // Synchronise reset release, then hold rst_out low for por_cycles more edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b00;
      por_cnt_q <= 8'd0;
      rst_out_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (sync_q[1] && !rst_out_q) begin
        if (por_cnt_q == c_por_last) begin
          rst_out_q <= 1'b1;
        end else begin
          por_cnt_q <= por_cnt_q + 8'd1;
        end
      end
    end
  end

  assign rst_out = rst_out_q;

  // --------------------------------------------------------------------------
  // Wait-state FSM
  // --------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       w_cpu_enable;

  // State and stall-counter registers. A reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and advance strobe. The FSM is frozen in IDLE while rst_out is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_cpu_enable = 1'b0;
    if (rst_out_q) begin
      case (state_q)
        S_IDLE: begin
          if (w_ws == 3'd0) begin
            w_cpu_enable = 1'b1;
          end else begin
            cnt_d   = w_ws - 3'd1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            w_cpu_enable = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus outputs
  // --------------------------------------------------------------------------
  assign cpu.cpu_enable   = w_cpu_enable;
  assign cpu.cpu_rdata    = rst_out_q ? w_rdata : '0;
  assign mem.inst_en      = w_sel_inst;
  assign mem.data_en      = w_sel_data;
  assign mem.periph_en    = w_sel_periph;
  assign mem.mem_addr     = w_offset;
  assign mem.mem_wdata    = cpu.cpu_wdata;
  assign mem.mem_write_en = cpu.cpu_write_en & w_cpu_enable & w_mapped;

  // --------------------------------------------------------------------------
  // Bus-error capture
  // --------------------------------------------------------------------------
`ifdef REFLET_MEM_MAP_BUS_ERR_EN
  logic                bus_err_q;
  logic [wordsize-1:0] err_addr_q;
  logic                w_err_evt;

  assign w_err_evt = w_cpu_enable & ~w_mapped;

  // Sticky error flag that keeps the first faulting address. A new error in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (w_err_evt) begin
      bus_err_q <= 1'b1;
      if (!bus_err_q || err_clr) begin
        err_addr_q <= cpu.cpu_addr;
      end
    end else if (err_clr) begin
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end
  end

  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign bus_err          = 1'b0;
  assign err_addr         = '0;
`endif

endmodule

`default_nettype wire
